fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage: owns the PC, drives the synchronous IMEM read port and
//  buffers {pc,instr} pairs in a DEPTH-entry prefetch queue. Decode pulls instructions over a
//  valid/ready handshake. A redirect (branch/call/ret resolved downstream) flushes the queue and
//  drops in-flight reads. Replaces the single IF/OF register with a stall-tolerant, width-generic
//  front end.
// PARAMETERS
//  XLEN      32  PC / data width
//  ILEN      32  instruction width
//  IADDR_W   10  IMEM word-address width (imem_addr = pc[IADDR_W+1:2])
//  DEPTH     4   prefetch queue entries; power of 2, >=2
//  RESET_PC  0   PC loaded on reset
// PORTS
//  clk            in   1        clock, all state on posedge
//  rst            in   1        synchronous active-high reset
//  start          in   1        fetch enable; 0 = stop issuing new reads
//  redirect_valid in   1        flush + new fetch target this cycle
//  redirect_pc    in   XLEN     target PC; bits [1:0] ignored (treated as 00)
//  imem_en        out  1        IMEM read strobe
//  imem_addr      out  IADDR_W  IMEM word address
//  imem_data      in   ILEN     IMEM read data, valid exactly 1 cycle after imem_en
//  if_valid       out  1        queue head valid
//  if_ready       in   1        decode accepts head (fire = if_valid & if_ready)
//  if_pc          out  XLEN     PC of head instruction
//  if_instr       out  ILEN     head instruction
// BEHAVIOUR
//  - Reset: fetch_pc<=RESET_PC, queue empty, inflight<=0; outputs: imem_en=0, if_valid=0,
//    if_pc=0, if_instr=0.
//  - FSM {IDLE,RUN}: IDLE->RUN when start=1; RUN->IDLE when start=0. In IDLE no issue; an in-flight
//    read still completes into the queue.
//  - Issue (RUN): imem_en=1 iff count + inflight - fire < DEPTH and !redirect_valid.
//    On issue: fetch_pc <= fetch_pc+4 (mod 2^XLEN, wraps to 0), inflight<=1, pc_q<=fetch_pc.
//  - Response: cycle after issue, {pc_q,imem_data} enqueued unless killed. Credit rule guarantees
//    queue never overflows; overflow is an assertion failure.
//  - Latency: issue at cycle N -> entry in queue and if_valid=1 at N+2 (registered queue output).
//    Sustained throughput 1 instr/cycle with if_ready=1 for any legal DEPTH.
//  - Empty: if_valid=0, if_pc/if_instr hold last value. Full: imem_en=0 until a fire frees a slot.
//  - Simultaneous enqueue+dequeue: count unchanged; on empty queue no bypass (N+2 latency holds).
//  - Redirect (highest priority): fire in the same cycle counts as accepted; all remaining entries
//    dropped (count<=0); any in-flight response is killed (not enqueued next cycle);
//    fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}; no issue this cycle; first issue at target next cycle.
//    Redirect while IDLE updates fetch_pc only.
//  - rst asserted mid-operation overrides everything, incl. redirect and a pending response.
// CONFIGURATION
//  IFQ_PERF_CNT_EN defined: adds outputs perf_fetched[31:0] (+1 per enqueued instr),
//    perf_flushed[31:0] (+entries dropped + killed in-flight per redirect), perf_stall[31:0]
//    (+1 per cycle with if_valid=1 & if_ready=0); saturate at 2^32-1, cleared by rst.
//  Not defined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  cpu_pkg: typedef fetch_entry_t {logic [XLEN-1:0] pc; logic [ILEN-1:0] instr;},
//    localparam INSTR_NOP, typedef fetch_state_t {IDLE,RUN}.
//  Sub-module ifq_fifo: sync FIFO of fetch_entry_t, DEPTH entries, push/pop/flush, count out.
// TESTING
//  1 reset, start=1, if_ready=1, IMEM[i]=0x1000_0000+i: imem_addr 0,1,2..; if_valid first at
//    cycle 2, if_pc 0,4,8.. one per cycle, instr 0x1000_0000..
//  2 DEPTH=4, if_ready=0 for 10 cycles: exactly 4 reads issued, imem_en=0 after; release ->
//    pc 0,4,8,12,16 in order, no loss/duplicate.
//  3 redirect_valid with redirect_pc=0x0000_0103 while 3 queued + 1 in flight: next valid
//    if_pc=0x100, no stale pc delivered, perf_flushed+=4 when IFQ_PERF_CNT_EN.
//  4 RESET_PC=0xFFFF_FFF8, run: if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
//  5 start toggles 1->0 with read in flight: that entry delivered, no further imem_en until start=1.
//  6 rst pulsed with queue full and redirect_valid=1: next cycle if_valid=0, imem_en=0;
//    restart fetches RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: queue entry, fetch FSM states, NOP encoding.
// Also holds the saturating 32-bit add used by the optional perf counters.
package cpu_pkg;

  localparam int XLEN_D = 32;
  localparam int ILEN_D = 32;

  localparam logic [ILEN_D-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_D-1:0] pc;
    logic [ILEN_D-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    IDLE,
    RUN
  } fetch_state_t;

  function automatic logic [31:0] sat_add32(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous prefetch FIFO with flush; head is read straight from storage.
// DEPTH must be a power of two so the pointers wrap for free.
module ifq_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  T              wdata,
  output T              rdata,
  output logic [CW-1:0] count
);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;
  logic           full;

  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= wdata;
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(do_push && !do_pop && full)
  );

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: PC, IMEM read port, prefetch queue, redirect flush.
// IFQ_PERF_CNT_EN adds perf_fetched/perf_flushed/perf_stall counters.
module fetch_prefetch_unit
  import cpu_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               ILEN     = 32,
  parameter int               IADDR_W  = 10,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_en,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [ILEN-1:0]    imem_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [XLEN-1:0]    if_pc,
  output logic [ILEN-1:0]    if_instr
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed,
  output logic [31:0]        perf_stall
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  fetch_state_t    state_q;
  fetch_state_t    state_n;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_q;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [CW:0]     credit;
  logic            fire;
  logic            issue;
  logic            push;
  entry_t          head;
  entry_t          hold;
  entry_t          wdata;
  logic            unused_rpc;

  assign unused_rpc = ^redirect_pc[1:0];

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (start)  state_n = RUN;
      RUN:     if (!start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign if_valid = (count != '0);
  assign fire     = if_valid & if_ready;
  assign credit   = {1'b0, count}
                  + (CW+1)'(inflight)
                  - (CW+1)'(fire);
  assign issue    = (state_n == RUN)
                  & ~redirect_valid
                  & ~rst
                  & (credit < (CW+1)'(DEPTH));

  assign imem_en   = issue;
  assign imem_addr = fetch_pc[IADDR_W+1:2];

  // A response landing in a redirect cycle belongs to the old path.
  assign push  = inflight & ~redirect_valid;
  assign wdata = '{pc: pc_q, instr: imem_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      fetch_pc <= RESET_PC;
      pc_q     <= '0;
      inflight <= 1'b0;
      hold     <= '0;
    end else begin
      state_q  <= state_n;
      inflight <= issue;
      if (issue) pc_q <= fetch_pc;
      if (redirect_valid)
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (issue)
        fetch_pc <= fetch_pc + XLEN'(4);
      if (if_valid) hold <= head;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fire),
    .flush (redirect_valid),
    .wdata (wdata),
    .rdata (head),
    .count (count)
  );

  // Empty queue keeps presenting the last head seen by decode.
  assign if_pc    = if_valid ? head.pc    : hold.pc;
  assign if_instr = if_valid ? head.instr : hold.instr;

`ifdef IFQ_PERF_CNT_EN
  logic [CW:0] dropped;

  assign dropped = {1'b0, count}
                 - (CW+1)'(fire)
                 + (CW+1)'(inflight);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
      perf_stall   <= '0;
    end else begin
      if (push)
        perf_fetched <= sat_add32(perf_fetched, 32'd1);
      if (redirect_valid)
        perf_flushed <= sat_add32(perf_flushed, 32'(dropped));
      if (if_valid && !if_ready)
        perf_stall <= sat_add32(perf_stall, 32'd1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: per-cycle vector table on the
// default instance plus a wrap sequence on a RESET_PC=FFFF_FFF8 instance.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, rv, rdy;
  logic [31:0] rpc;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data = '0;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;

  logic        w_rst, w_start, w_rv, w_rdy;
  logic [31:0] w_rpc;
  logic        w_en;
  logic [9:0]  w_addr;
  logic [31:0] w_data = '0;
  logic        w_valid;
  logic [31:0] w_pc, w_instr;

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] p_fetch, p_flush, p_stall;
  logic [31:0] wp_fetch, wp_flush, wp_stall;
`endif

  fetch_prefetch_unit u_dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .redirect_valid (rv),
    .redirect_pc    (rpc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_valid       (if_valid),
    .if_ready       (rdy),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
`ifdef IFQ_PERF_CNT_EN
    ,
    .perf_fetched   (p_fetch),
    .perf_flushed   (p_flush),
    .perf_stall     (p_stall)
`endif
  );

  fetch_prefetch_unit #(
    .RESET_PC (32'hFFFF_FFF8)
  ) u_wrap (
    .clk            (clk),
    .rst            (w_rst),
    .start          (w_start),
    .redirect_valid (w_rv),
    .redirect_pc    (w_rpc),
    .imem_en        (w_en),
    .imem_addr      (w_addr),
    .imem_data      (w_data),
    .if_valid       (w_valid),
    .if_ready       (w_rdy),
    .if_pc          (w_pc),
    .if_instr       (w_instr)
`ifdef IFQ_PERF_CNT_EN
    ,
    .perf_fetched   (wp_fetch),
    .perf_flushed   (wp_flush),
    .perf_stall     (wp_stall)
`endif
  );

  // IMEM models: word i holds 0x1000_0000 + i, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_data <= 32'h1000_0000 + 32'(imem_addr);
    if (w_en)    w_data    <= 32'h1000_0000 + 32'(w_addr);
  end

  typedef struct {
    logic        rst, start, rdy, rv;
    logic [31:0] rpc;
    logic        en;
    logic [9:0]  addr;
    logic        v;
    logic [31:0] pc, instr;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   perf_row;

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return 32'h1000_0000 + (pc >> 2);
  endfunction

  task automatic add(
    input logic r, s, y, x,
    input logic [31:0] p,
    input logic e,
    input logic [9:0] a,
    input logic v,
    input logic [31:0] pc, i
  );
    vec_t t;
    t.rst = r; t.start = s; t.rdy = y; t.rv = x; t.rpc = p;
    t.en = e; t.addr = a; t.v = v; t.pc = pc; t.instr = i;
    tbl.push_back(t);
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    rst = 1; start = 0; rv = 0; rdy = 0; rpc = '0;
    w_rst = 1; w_start = 0; w_rv = 0; w_rdy = 0; w_rpc = '0;

    // reset state
    add(1,0,0,0,0, 0,0,    0,0,0);
    add(1,0,0,0,0, 0,0,    0,0,0);
    // streaming, ready=1
    add(0,1,1,0,0, 1,0,    0,0,0);
    add(0,1,1,0,0, 1,1,    0,0,0);
    add(0,1,1,0,0, 1,2,    1,0,ins(0));
    add(0,1,1,0,0, 1,3,    1,4,ins(4));
    add(0,1,1,0,0, 1,4,    1,8,ins(8));
    // reset with a read in flight
    add(1,1,0,0,0, 0,0,    1,12,ins(12));
    add(1,1,0,0,0, 0,0,    0,0,0);
    // decode stalled: four reads then full
    add(0,1,0,0,0, 1,0,    0,0,0);
    add(0,1,0,0,0, 1,1,    0,0,0);
    add(0,1,0,0,0, 1,2,    1,0,ins(0));
    add(0,1,0,0,0, 1,3,    1,0,ins(0));
    for (int k = 0; k < 6; k++)
      add(0,1,0,0,0, 0,0,  1,0,ins(0));
    // release
    add(0,1,1,0,0, 1,4,    1,0,ins(0));
    add(0,1,1,0,0, 1,5,    1,4,ins(4));
    add(0,1,1,0,0, 1,6,    1,8,ins(8));
    add(0,1,1,0,0, 1,7,    1,12,ins(12));
    add(0,1,1,0,0, 1,8,    1,16,ins(16));
    // redirect with 3 queued + 1 in flight
    add(0,1,0,1,32'h103, 0,0, 1,20,ins(20));
    perf_row = tbl.size();
    add(0,1,0,0,0, 1,10'h40, 0,20,ins(20));
    add(0,1,1,0,0, 1,10'h41, 0,20,ins(20));
    add(0,1,1,0,0, 1,10'h42, 1,32'h100,ins(32'h100));
    add(0,1,1,0,0, 1,10'h43, 1,32'h104,ins(32'h104));
    // stop with a read in flight
    add(0,0,1,0,0, 0,0, 1,32'h108,ins(32'h108));
    add(0,0,1,0,0, 0,0, 1,32'h10C,ins(32'h10C));
    add(0,0,1,0,0, 0,0, 0,32'h10C,ins(32'h10C));
    add(0,1,0,0,0, 1,10'h44, 0,32'h10C,ins(32'h10C));
    add(0,1,0,0,0, 1,10'h45, 0,32'h10C,ins(32'h10C));
    add(0,1,0,0,0, 1,10'h46, 1,32'h110,ins(32'h110));
    add(0,1,0,0,0, 1,10'h47, 1,32'h110,ins(32'h110));
    add(0,1,0,0,0, 0,0, 1,32'h110,ins(32'h110));
    add(0,1,0,0,0, 0,0, 1,32'h110,ins(32'h110));
    // reset + redirect with full queue
    add(1,1,0,1,32'h200, 0,0, 1,32'h110,ins(32'h110));
    add(1,1,0,1,32'h200, 0,0, 0,0,0);
    add(0,1,1,0,0, 1,0, 0,0,0);
    add(0,1,1,0,0, 1,1, 0,0,0);
    add(0,1,1,0,0, 1,2, 1,0,ins(0));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; start = tbl[i].start;
      rdy = tbl[i].rdy; rv = tbl[i].rv; rpc = tbl[i].rpc;
      #1;
      chk($sformatf("r%0d en", i), 32'(imem_en), 32'(tbl[i].en));
      if (tbl[i].en)
        chk($sformatf("r%0d addr", i),
            32'(imem_addr), 32'(tbl[i].addr));
      chk($sformatf("r%0d valid", i), 32'(if_valid), 32'(tbl[i].v));
      chk($sformatf("r%0d pc", i), if_pc, tbl[i].pc);
      chk($sformatf("r%0d instr", i), if_instr, tbl[i].instr);
`ifdef IFQ_PERF_CNT_EN
      if (i == perf_row) begin
        chk("perf_fetched", p_fetch, 32'd8);
        chk("perf_flushed", p_flush, 32'd4);
        chk("perf_stall",   p_stall, 32'd9);
      end
`endif
    end

    // PC wrap from RESET_PC=FFFF_FFF8
    @(negedge clk);
    w_rst = 0; w_start = 1; w_rdy = 1;
    #1;
    chk("wrap en0", 32'(w_en), 32'd1);
    chk("wrap addr0", 32'(w_addr), 32'h3FE);
    @(negedge clk); #1;
    chk("wrap addr1", 32'(w_addr), 32'h3FF);
    chk("wrap valid1", 32'(w_valid), 32'd0);
    @(negedge clk); #1;
    chk("wrap addr2", 32'(w_addr), 32'h000);
    chk("wrap valid2", 32'(w_valid), 32'd1);
    chk("wrap pc2", w_pc, 32'hFFFF_FFF8);
    chk("wrap instr2", w_instr, 32'h1000_03FE);
    @(negedge clk); #1;
    chk("wrap pc3", w_pc, 32'hFFFF_FFFC);
    chk("wrap instr3", w_instr, 32'h1000_03FF);
    @(negedge clk); #1;
    chk("wrap pc4", w_pc, 32'h0000_0000);
    chk("wrap instr4", w_instr, 32'h1000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
